// File: rtl/cca_region_stats_if.sv
// Signal bundle between the CCA labeller, cca_region_stats and the particle-filter front end.
// The slave modport is the region-stats block's view; master is the driver/consumer side.
interface cca_region_stats_if #(
    parameter int COORD_W = 8,
    parameter int CNT_W   = 14
);
    logic               pix_valid_in;
    logic [6:0]         lbl_0_in;
    logic [6:0]         lbl_1_in;
    logic               frame_end_in;
    logic               stat_valid_out;
    logic               stat_ready_in;
    logic [6:0]         stat_label_out;
    logic [CNT_W-1:0]   stat_count_out;
    logic [COORD_W-1:0] stat_xmin_out;
    logic [COORD_W-1:0] stat_xmax_out;
    logic [COORD_W-1:0] stat_ymin_out;
    logic [COORD_W-1:0] stat_ymax_out;
    logic               dump_done_out;
    logic               busy_out;
    logic               overrun_out;

    modport master (
        output pix_valid_in, lbl_0_in, lbl_1_in, frame_end_in, stat_ready_in,
        input  stat_valid_out, stat_label_out, stat_count_out,
               stat_xmin_out, stat_xmax_out, stat_ymin_out, stat_ymax_out,
               dump_done_out, busy_out, overrun_out
    );

    modport slave (
        input  pix_valid_in, lbl_0_in, lbl_1_in, frame_end_in, stat_ready_in,
        output stat_valid_out, stat_label_out, stat_count_out,
               stat_xmin_out, stat_xmax_out, stat_ymin_out, stat_ymax_out,
               dump_done_out, busy_out, overrun_out
    );
endinterface

// File: rtl/cca_region_stats.sv
// Per-label pixel count and bounding box accumulator over one frame of two-lane CCA labels;
// the non-empty records are streamed out in ascending label order at frame end.
module cca_region_stats #(
    parameter int IMG_W   = 128,
    parameter int IMG_H   = 96,
    parameter int COORD_W = 8,
    parameter int CNT_W   = 14
) (
    input  logic              clk,
    input  logic              reset,
    cca_region_stats_if.slave bus
);
    typedef enum logic [1:0] {S_CLEAR, S_ACCUM, S_DUMP} state_t;

    typedef struct packed {
        logic [CNT_W-1:0]   count;
        logic [COORD_W-1:0] xmin;
        logic [COORD_W-1:0] xmax;
        logic [COORD_W-1:0] ymin;
        logic [COORD_W-1:0] ymax;
    } entry_t;

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 2);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 1);
    localparam entry_t EMPTY = {{CNT_W{1'b0}}, {COORD_W{1'b1}}, {COORD_W{1'b0}},
                                {COORD_W{1'b1}}, {COORD_W{1'b0}}};

    state_t             state_q, state_d;
    logic [6:0]         idx_q, idx_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    entry_t             tbl_q [128];
    entry_t             tbl_d [128];
    logic               stat_valid_q, stat_valid_d;
    entry_t             stat_rec_q, stat_rec_d;
    logic [6:0]         stat_label_q, stat_label_d;
    logic               dump_done_q, dump_done_d;
    logic               overrun_q, overrun_d;
    logic [COORD_W-1:0] x_hi;
    logic               advance;

    // Merge pixel(s) spanning columns xa..xb on row py into a record, count saturating.
    function automatic entry_t extend(entry_t e, logic [COORD_W-1:0] xa,
                                      logic [COORD_W-1:0] xb, logic [COORD_W-1:0] py,
                                      logic [1:0] inc);
        entry_t         r;
        logic [CNT_W:0] sum;
        r       = e;
        sum     = {1'b0, e.count} + {{(CNT_W-1){1'b0}}, inc};
        r.count = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        if (xa < r.xmin) r.xmin = xa;
        if (xb > r.xmax) r.xmax = xb;
        if (py < r.ymin) r.ymin = py;
        if (py > r.ymax) r.ymax = py;
        return r;
    endfunction

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        x_d          = x_q;
        y_d          = y_q;
        tbl_d        = tbl_q;
        stat_valid_d = stat_valid_q;
        stat_rec_d   = stat_rec_q;
        stat_label_d = stat_label_q;
        dump_done_d  = 1'b0;
        overrun_d    = overrun_q;
        advance      = 1'b0;
        x_hi         = x_q + COORD_W'(1);

        unique case (state_q)
            S_CLEAR: begin
                tbl_d[idx_q] = EMPTY;
                if (bus.pix_valid_in || bus.frame_end_in) overrun_d = 1'b1;
                if (idx_q == 7'd127) begin
                    state_d = S_ACCUM;
                    idx_d   = 7'd0;
                    x_d     = '0;
                    y_d     = '0;
                end else begin
                    idx_d = idx_q + 7'd1;
                end
            end
            S_ACCUM: begin
                if (bus.pix_valid_in) begin
                    // Equal lane labels would otherwise race two writes into one entry.
                    if (bus.lbl_0_in != 7'd0 && bus.lbl_0_in == bus.lbl_1_in) begin
                        tbl_d[bus.lbl_0_in] = extend(tbl_q[bus.lbl_0_in], x_q, x_hi, y_q, 2'd2);
                    end else begin
                        if (bus.lbl_0_in != 7'd0)
                            tbl_d[bus.lbl_0_in] = extend(tbl_q[bus.lbl_0_in], x_q, x_q, y_q, 2'd1);
                        if (bus.lbl_1_in != 7'd0)
                            tbl_d[bus.lbl_1_in] = extend(tbl_q[bus.lbl_1_in], x_hi, x_hi, y_q, 2'd1);
                    end
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = (y_q == Y_LAST) ? '0 : y_q + COORD_W'(1);
                    end else begin
                        x_d = x_q + COORD_W'(2);
                    end
                end
                if (bus.frame_end_in) begin
                    state_d = S_DUMP;
                    idx_d   = 7'd1;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            S_DUMP: begin
                if (bus.pix_valid_in || bus.frame_end_in) overrun_d = 1'b1;
                if (stat_valid_q) begin
                    if (bus.stat_ready_in) begin
                        stat_valid_d = 1'b0;
                        advance      = 1'b1;
                    end
                end else if (tbl_q[idx_q].count != '0) begin
                    stat_valid_d = 1'b1;
                    stat_rec_d   = tbl_q[idx_q];
                    stat_label_d = idx_q;
                end else begin
                    advance = 1'b1;
                end
                if (advance) begin
                    if (idx_q == 7'd127) begin
                        state_d     = S_CLEAR;
                        idx_d       = 7'd0;
                        dump_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 7'd1;
                    end
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_CLEAR;
            idx_q        <= 7'd0;
            x_q          <= '0;
            y_q          <= '0;
            stat_valid_q <= 1'b0;
            stat_rec_q   <= '0;
            stat_label_q <= 7'd0;
            dump_done_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            x_q          <= x_d;
            y_q          <= y_d;
            stat_valid_q <= stat_valid_d;
            stat_rec_q   <= stat_rec_d;
            stat_label_q <= stat_label_d;
            dump_done_q  <= dump_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // The table needs no reset: every reset leads through a full CLEAR pass.
    always_ff @(posedge clk) begin
        tbl_q <= tbl_d;
    end

    assign bus.stat_valid_out = stat_valid_q;
    assign bus.stat_label_out = stat_label_q;
    assign bus.stat_count_out = stat_rec_q.count;
    assign bus.stat_xmin_out  = stat_rec_q.xmin;
    assign bus.stat_xmax_out  = stat_rec_q.xmax;
    assign bus.stat_ymin_out  = stat_rec_q.ymin;
    assign bus.stat_ymax_out  = stat_rec_q.ymax;
    assign bus.dump_done_out  = dump_done_q;
    assign bus.busy_out       = (state_q != S_ACCUM);
    assign bus.overrun_out    = overrun_q;
endmodule

// File: tb/tb_cca_region_stats.sv
// Scoreboard bench for cca_region_stats: a per-pixel reference model queues the expected
// records at frame end and a monitor checks each accepted record and dump_done pulse.
module tb_cca_region_stats;
    localparam int IMG_W   = 128;
    localparam int IMG_H   = 96;
    localparam int COORD_W = 8;
    localparam int CNT_W   = 14;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [6:0]         label;
        logic [CNT_W-1:0]   count;
        logic [COORD_W-1:0] xmin;
        logic [COORD_W-1:0] xmax;
        logic [COORD_W-1:0] ymin;
        logic [COORD_W-1:0] ymax;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic hold_ready = 1'b0;

    int   n_vec = 0;
    int   n_err = 0;
    rec_t sb[$];

    int m_cnt [128];
    int m_xmin[128];
    int m_xmax[128];
    int m_ymin[128];
    int m_ymax[128];
    int mx = 0;
    int my = 0;

    cca_region_stats_if #(.COORD_W(COORD_W), .CNT_W(CNT_W)) bus ();

    cca_region_stats #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .COORD_W(COORD_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 128; i++) begin
            m_cnt[i]  = 0;
            m_xmin[i] = 255;
            m_xmax[i] = 0;
            m_ymin[i] = 255;
            m_ymax[i] = 0;
        end
        mx = 0;
        my = 0;
    endfunction

    function automatic void model_pixel(input int l, input int px, input int py);
        if (l == 0) return;
        m_cnt[l]  = (m_cnt[l] + 1 > CNT_MAX) ? CNT_MAX : m_cnt[l] + 1;
        m_xmin[l] = (px < m_xmin[l]) ? px : m_xmin[l];
        m_xmax[l] = (px > m_xmax[l]) ? px : m_xmax[l];
        m_ymin[l] = (py < m_ymin[l]) ? py : m_ymin[l];
        m_ymax[l] = (py > m_ymax[l]) ? py : m_ymax[l];
    endfunction

    function automatic void model_beat(input int l0, input int l1);
        model_pixel(l0, mx, my);
        model_pixel(l1, mx + 1, my);
        mx += 2;
        if (mx == IMG_W) begin
            mx = 0;
            my = (my + 1) % IMG_H;
        end
    endfunction

    // Expected records in label order, then an all-zero marker standing for dump_done.
    function automatic void model_frame_end();
        rec_t r;
        for (int l = 1; l < 128; l++) begin
            if (m_cnt[l] > 0) begin
                r.label = 7'(l);
                r.count = CNT_W'(m_cnt[l]);
                r.xmin  = COORD_W'(m_xmin[l]);
                r.xmax  = COORD_W'(m_xmax[l]);
                r.ymin  = COORD_W'(m_ymin[l]);
                r.ymax  = COORD_W'(m_ymax[l]);
                sb.push_back(r);
            end
        end
        sb.push_back('0);
        model_clear();
    endfunction

    task automatic apply_stimulus(input logic v, input logic [6:0] l0, input logic [6:0] l1,
                                  input logic fe, input logic to_model);
        bus.pix_valid_in = v;
        bus.lbl_0_in     = l0;
        bus.lbl_1_in     = l1;
        bus.frame_end_in = fe;
        if (to_model) begin
            if (v) model_beat(int'(l0), int'(l1));
            if (fe) model_frame_end();
        end
        @(posedge clk);
        #1;
        bus.pix_valid_in = 1'b0;
        bus.lbl_0_in     = 7'd0;
        bus.lbl_1_in     = 7'd0;
        bus.frame_end_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy_out && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("idle_timeout", 64'(bus.busy_out), 64'd0);
        check_output("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    task automatic wait_valid(input int limit);
        int n = 0;
        while (!bus.stat_valid_out && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("valid_timeout", 64'(bus.stat_valid_out), 64'd1);
    endtask

    task automatic do_reset();
        int   n = 0;
        logic saw_valid = 1'b0;
        reset      = 1'b1;
        hold_ready = 1'b0;
        @(posedge clk);
        #1;
        check_output("valid_after_reset", 64'(bus.stat_valid_out), 64'd0);
        check_output("overrun_after_reset", 64'(bus.overrun_out), 64'd0);
        check_output("done_after_reset", 64'(bus.dump_done_out), 64'd0);
        @(posedge clk);
        #1;
        sb.delete();
        model_clear();
        reset = 1'b0;
        while (bus.busy_out && n < 1000) begin
            if (bus.stat_valid_out) saw_valid = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        check_output("clear_busy_cycles", 64'(n), 64'd128);
        check_output("valid_during_clear", 64'(saw_valid), 64'd0);
    endtask

    function automatic logic [6:0] rect_lbl(input int px, input int py);
        if (px >= 4 && px <= 21 && py >= 2 && py <= 10) return 7'd3;
        if (px >= 99 && py >= 50) return 7'd7;
        return 7'd0;
    endfunction

    task automatic run_rect_frame();
        int px;
        int py;
        for (int b = 0; b < (IMG_W / 2) * IMG_H; b++) begin
            px = (b % (IMG_W / 2)) * 2;
            py = b / (IMG_W / 2);
            apply_stimulus(1'b1, rect_lbl(px, py), rect_lbl(px + 1, py), 1'b0, 1'b1);
        end
        repeat (3) apply_stimulus(1'b1, 7'd11, 7'd11, 1'b0, 1'b1);
    endtask

    // Labels stay in 1..15 so that label 120 never occurs legitimately.
    task automatic random_frame(input int beats);
        logic [6:0] l0;
        logic [6:0] l1;
        for (int i = 0; i < beats; i++) begin
            if ($urandom_range(7) == 0) begin
                apply_stimulus(1'b0, 7'd0, 7'd0, 1'b0, 1'b1);
            end else begin
                l0 = ($urandom_range(2) == 0) ? 7'd0 : 7'($urandom_range(15, 1));
                l1 = ($urandom_range(2) == 0) ? l0 :
                     (($urandom_range(2) == 0) ? 7'd0 : 7'($urandom_range(15, 1)));
                apply_stimulus(1'b1, l0, l1, 1'b0, 1'b1);
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        bus.stat_ready_in = hold_ready ? 1'b0 : ($urandom_range(3) != 0);
    end

    rec_t prev_rec;
    logic prev_wait = 1'b0;

    // Monitor: at mid-cycle the handshake about to complete at the next edge is visible.
    always @(negedge clk) begin
        rec_t got;
        rec_t exp_r;
        got = {bus.stat_label_out, bus.stat_count_out, bus.stat_xmin_out,
               bus.stat_xmax_out, bus.stat_ymin_out, bus.stat_ymax_out};
        if (reset !== 1'b0) begin
            prev_wait = 1'b0;
        end else begin
            if (prev_wait) begin
                check_output("valid_held", 64'(bus.stat_valid_out), 64'd1);
                check_output("fields_held", 64'(got), 64'(prev_rec));
            end
            if (bus.stat_valid_out && bus.stat_ready_in) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("[TB] FAIL unexpected_record: got 0x%0h, expected none", got);
                end else begin
                    exp_r = sb.pop_front();
                    check_output("record", 64'(got), 64'(exp_r));
                end
            end
            if (bus.dump_done_out) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("[TB] FAIL unexpected_dump_done: got pulse, expected none");
                end else begin
                    exp_r = sb.pop_front();
                    check_output("dump_done_order", 64'(exp_r), 64'd0);
                end
            end
            prev_wait = bus.stat_valid_out && !bus.stat_ready_in;
            prev_rec  = got;
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.pix_valid_in  = 1'b0;
        bus.lbl_0_in      = 7'd0;
        bus.lbl_1_in      = 7'd0;
        bus.frame_end_in  = 1'b0;
        bus.stat_ready_in = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single 5/5 beat at x=10, y=3.
        repeat (3 * (IMG_W / 2) + 5) apply_stimulus(1'b1, 7'd0, 7'd0, 1'b0, 1'b1);
        apply_stimulus(1'b1, 7'd5, 7'd5, 1'b0, 1'b1);
        apply_stimulus(1'b0, 7'd0, 7'd0, 1'b1, 1'b1);
        wait_idle();

        // Full frame with two rectangles, then three beats past the wrap.
        run_rect_frame();
        apply_stimulus(1'b0, 7'd0, 7'd0, 1'b1, 1'b1);
        wait_idle();

        // Beat merged with frame_end, stalled consumer, beat during DUMP.
        random_frame(300);
        hold_ready = 1'b1;
        check_output("overrun_before", 64'(bus.overrun_out), 64'd0);
        apply_stimulus(1'b1, 7'd2, 7'd2, 1'b1, 1'b1);
        apply_stimulus(1'b1, 7'd120, 7'd120, 1'b0, 1'b0);
        check_output("overrun_set", 64'(bus.overrun_out), 64'd1);
        wait_valid(200);
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check_output("valid_stalled", 64'(bus.stat_valid_out), 64'd1);
        hold_ready = 1'b0;
        wait_idle();
        check_output("overrun_sticky", 64'(bus.overrun_out), 64'd1);

        // Reset in the middle of a dump.
        random_frame(200);
        hold_ready = 1'b1;
        apply_stimulus(1'b0, 7'd0, 7'd0, 1'b1, 1'b1);
        wait_valid(200);
        do_reset();

        for (int f = 0; f < 3; f++) begin
            random_frame(250);
            apply_stimulus(1'b0, 7'd0, 7'd0, 1'b1, 1'b1);
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
